// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_if
// Description : Instruction- and data-memory req/ack bus of the multicycle
//               sequencer.
//               master : sequencer side (drives requests, receives acks)
//               slave  : memory side   (receives requests, drives acks)
//   imem_req   master->slave  instruction fetch request
//   imem_addr  master->slave  fetch address (PC)
//   imem_ack   slave->master  fetch complete, imem_rdata valid
//   imem_rdata slave->master  fetched instruction
//   dmem_req   master->slave  data access request
//   dmem_we    master->slave  1=store, 0=load; valid while dmem_req
//   dmem_ack   slave->master  data access complete
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_sequencer_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) ();
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : PC/IR owner and multicycle control FSM. Sequences
//               FETCH/DECODE/EXEC/MEM/WB over req/ack memories with
//               variable wait states, with run/pause, halt, a watchdog
//               on every request and a retired-instruction counter.
// Ports       :
//   CLK, resetl      clock (posedge) / asynchronous active-low reset
//   startpc          PC loaded when leaving IDLE
//   run              1=execute, 0=pause at the next instruction boundary
//   bus              memory req/ack interface (master side)
//   instr            instruction register
//   dec_*            decoded controls for instr (external control block)
//   alu_zero         ALU zero flag
//   br_offset        sign-extended branch offset in words
//   rf_we            register-file write strobe (one cycle, in WB)
//   pc               current PC
//   state            FSM encoding (IDLE=0 ... HALT=7)
//   halted           1 in HALT
//   timeout_err      sticky watchdog flag
//   retired          completed-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int                 ADDR_W     = 64,
    parameter int                 INSTR_W    = 32,
    parameter int                 CNT_W      = 32,
    parameter int                 MAX_WAIT   = 255,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 32'hD4400000
) (
    input  wire logic                CLK,
    input  wire logic                resetl,
    input  wire logic [ADDR_W-1:0]   startpc,
    input  wire logic                run,
    multicycle_sequencer_if.master   bus,
    output logic      [INSTR_W-1:0]  instr,
    input  wire logic                dec_memread,
    input  wire logic                dec_memwrite,
    input  wire logic                dec_regwrite,
    input  wire logic                dec_branch,
    input  wire logic                dec_uncond,
    input  wire logic                alu_zero,
    input  wire logic [ADDR_W-1:0]   br_offset,
    output logic                     rf_we,
    output logic      [ADDR_W-1:0]   pc,
    output logic      [2:0]          state,
    output logic                     halted,
    output logic                     timeout_err,
    output logic      [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PAUSE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // The counter only ever holds 0..MAX_WAIT-1: the MAX_WAIT-th ack-less
    // request cycle triggers the timeout instead of another increment.
    localparam int               WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic              fetch_req;
    logic              data_req;
    logic              data_we;

    logic              take_branch;
    logic [ADDR_W-1:0] pc_next;
    logic              mem_access;
    logic              is_load;
    logic              boundary;

    assign take_branch = dec_uncond | (dec_branch & alu_zero);
    assign pc_next     = take_branch ? (pc + (br_offset << 2)) : (pc + ADDR_W'(4));
    assign mem_access  = dec_memread | dec_memwrite;
    // memread together with memwrite is a store: no write-back.
    assign is_load     = dec_memread & ~dec_memwrite;

    // Instruction completes this cycle: EXEC with nothing left to do, a MEM
    // store/ack without write-back, or WB.
    assign boundary = ((st == S_EXEC) && !mem_access && !dec_regwrite)
                   || ((st == S_MEM) && bus.dmem_ack && !is_load)
                   ||  (st == S_WB);

    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = data_req;
    assign bus.dmem_we   = data_we;
    assign state         = st;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            st          <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            retired     <= '0;
            fetch_req   <= 1'b0;
            data_req    <= 1'b0;
            data_we     <= 1'b0;
            rf_we       <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else if (boundary) begin
            pc        <= pc_next;
            retired   <= retired + CNT_W'(1);
            data_req  <= 1'b0;
            data_we   <= 1'b0;
            rf_we     <= 1'b0;
            wait_cnt  <= '0;
            fetch_req <= run;
            st        <= run ? S_FETCH : S_PAUSE;
        end else begin
            case (st)
                S_IDLE: begin
                    if (run) begin
                        pc        <= startpc;
                        wait_cnt  <= '0;
                        fetch_req <= 1'b1;
                        st        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr     <= bus.imem_rdata;
                        fetch_req <= 1'b0;
                        st        <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        fetch_req   <= 1'b0;
                        halted      <= 1'b1;
                        st          <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (instr == HALT_INSTR) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Only reached here when the instruction needs MEM or WB.
                    if (mem_access) begin
                        data_req <= 1'b1;
                        data_we  <= dec_memwrite;
                        wait_cnt <= '0;
                        st       <= S_MEM;
                    end else begin
                        rf_we <= 1'b1;
                        st    <= S_WB;
                    end
                end
                S_MEM: begin
                    // An ack here is a load; store acks are boundaries.
                    if (bus.dmem_ack) begin
                        data_req <= 1'b0;
                        data_we  <= 1'b0;
                        rf_we    <= 1'b1;
                        st       <= S_WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        data_req    <= 1'b0;
                        data_we     <= 1'b0;
                        halted      <= 1'b1;
                        st          <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (run) begin
                        wait_cnt  <= '0;
                        fetch_req <= 1'b1;
                        st        <= S_FETCH;
                    end
                end
                S_WB: begin
                    // Always a boundary; handled above.
                end
                S_HALT: begin
                    // Terminal until reset.
                end
                default: begin
                    st <= S_HALT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Self-checking bench for multicycle_sequencer. Memory
//               responders with programmable waits, a stand-in control
//               block decoding a small bench ISA, directed scenarios and
//               randomized programs checked through an event scoreboard fed
//               by an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;
    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam int          CNT_W    = 32;
    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] HALT_I   = 32'hD4400000;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_PAUSE = 3'd6, S_HALT = 3'd7;

    // Bench ISA: instr[31:28] opcode, instr[27] zero flag, instr[15:0] offset.
    localparam int OP_ALU = 0, OP_LD = 1, OP_ST = 2, OP_CBZ = 3, OP_B = 4, OP_LDST = 5, OP_NOP = 6;

    localparam logic [1:0] EV_FETCH = 2'd0, EV_DMEM = 2'd1, EV_RFW = 2'd2, EV_HALT = 2'd3;

    logic                CLK = 1'b0;
    logic                resetl;
    logic [ADDR_W-1:0]   startpc;
    logic                run;
    logic [INSTR_W-1:0]  instr;
    logic                dec_memread, dec_memwrite, dec_regwrite, dec_branch, dec_uncond;
    logic                alu_zero;
    logic [ADDR_W-1:0]   br_offset;
    logic                rf_we;
    logic [ADDR_W-1:0]   pc;
    logic [2:0]          state;
    logic                halted;
    logic                timeout_err;
    logic [CNT_W-1:0]    retired;
    logic [3:0]          op;

    multicycle_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) mif ();

    multicycle_sequencer #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W),
        .MAX_WAIT(MAX_WAIT), .HALT_INSTR(HALT_I)
    ) dut (
        .CLK(CLK), .resetl(resetl), .startpc(startpc), .run(run), .bus(mif),
        .instr(instr), .dec_memread(dec_memread), .dec_memwrite(dec_memwrite),
        .dec_regwrite(dec_regwrite), .dec_branch(dec_branch), .dec_uncond(dec_uncond),
        .alu_zero(alu_zero), .br_offset(br_offset), .rf_we(rf_we), .pc(pc),
        .state(state), .halted(halted), .timeout_err(timeout_err), .retired(retired)
    );

    always #5 CLK = ~CLK;

    // Stand-in control block.
    always_comb begin
        op           = instr[31:28];
        dec_memread  = (op == 4'(OP_LD)) || (op == 4'(OP_LDST));
        dec_memwrite = (op == 4'(OP_ST)) || (op == 4'(OP_LDST));
        dec_regwrite = (op == 4'(OP_ALU)) || (op == 4'(OP_LD)) || (op == 4'(OP_LDST));
        dec_branch   = (op == 4'(OP_CBZ));
        dec_uncond   = (op == 4'(OP_B));
        alu_zero     = instr[27];
        br_offset    = {{48{instr[15]}}, instr[15:0]};
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] mk(input int opc, input bit z, input int off);
        logic [31:0] v;
        v = {opc[3:0], z, 11'd0, off[15:0]};
        return v;
    endfunction

    // ---------------- memory responders ----------------
    logic [31:0] istream[$];
    int  imem_wait = 0;      // <0: random 0..3
    int  dmem_wait = 0;
    bit  imem_block = 0;
    bit  dmem_block = 0;
    bit  spurious = 0;

    initial begin
        int left = -1;
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
        forever begin
            @(negedge CLK);
            mif.imem_ack = 1'b0;
            if (!mif.imem_req) begin
                left = -1;
                if (spurious && $urandom_range(0, 3) == 0) begin
                    mif.imem_ack   = 1'b1;
                    mif.imem_rdata = $urandom;
                end
            end else if (!imem_block && istream.size() > 0) begin
                if (left < 0) left = (imem_wait >= 0) ? imem_wait : int'($urandom_range(0, 3));
                if (left == 0) begin
                    mif.imem_ack   = 1'b1;
                    mif.imem_rdata = istream.pop_front();
                    left = -1;
                end else begin
                    left--;
                end
            end
        end
    end

    initial begin
        int left = -1;
        mif.dmem_ack = 1'b0;
        forever begin
            @(negedge CLK);
            mif.dmem_ack = 1'b0;
            if (!mif.dmem_req) begin
                left = -1;
                if (spurious && $urandom_range(0, 3) == 0) mif.dmem_ack = 1'b1;
            end else if (!dmem_block) begin
                if (left < 0) left = (dmem_wait >= 0) ? dmem_wait : int'($urandom_range(0, 3));
                if (left == 0) begin
                    mif.dmem_ack = 1'b1;
                    left = -1;
                end else begin
                    left--;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] val;
    } ev_t;

    ev_t exp_q[$];
    bit  mon_en = 0;
    bit  rand_run = 0;
    logic p_ireq = 1'b0, p_dreq = 1'b0, p_halt = 1'b0;
    logic [63:0] model_pc;
    int          model_ret;

    task automatic push_exp(input logic [1:0] k, input logic [63:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic sb_event(input logic [1:0] k, input logic [63:0] v);
        ev_t e;
        check("sb_event_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_kind", 64'(k), 64'(e.kind));
            check("sb_val", v, e.val);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (mif.imem_req && !p_ireq) sb_event(EV_FETCH, mif.imem_addr);
            if (mif.dmem_req && !p_dreq) sb_event(EV_DMEM, 64'(mif.dmem_we));
            if (rf_we)                   sb_event(EV_RFW, 64'd0);
            if (halted && !p_halt)       sb_event(EV_HALT, 64'(retired));
            if (state == S_PAUSE) check("pause_quiet", {62'd0, mif.imem_req, mif.dmem_req}, 64'd0);
        end
        p_ireq = mif.imem_req;
        p_dreq = mif.dmem_req;
        p_halt = halted;
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (rand_run && $urandom_range(0, 7) == 0) run = ~run;
        end
    end

    // Instruction-level reference: builds a random program, feeds it to the
    // fetch responder and queues the events it must cause.
    task automatic model_program(input logic [63:0] spc, input int n);
        logic [63:0]        mpc;
        logic [31:0]        ins;
        logic signed [63:0] soff;
        int                 opc;
        int                 cnt;
        bit                 taken;
        mpc = spc;
        cnt = 0;
        for (int k = 0; k <= n; k++) begin
            if (k == n) ins = HALT_I;
            else ins = mk(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)));
            istream.push_back(ins);
            push_exp(EV_FETCH, mpc);
            if (k == n) begin
                push_exp(EV_HALT, 64'(cnt));
                break;
            end
            opc   = int'(ins[31:28]);
            taken = (opc == OP_B) || (opc == OP_CBZ && ins[27]);
            case (opc)
                OP_ALU:  push_exp(EV_RFW, 64'd0);
                OP_LD: begin
                    push_exp(EV_DMEM, 64'd0);
                    push_exp(EV_RFW, 64'd0);
                end
                OP_ST, OP_LDST: push_exp(EV_DMEM, 64'd1);
                default: ;
            endcase
            soff = $signed(ins[15:0]);
            mpc  = taken ? mpc + soff * 4 : mpc + 64'd4;
            cnt++;
        end
        model_pc  = mpc;
        model_ret = cnt;
    endtask

    // Run one instruction from the current FETCH to its boundary, counting
    // strobe cycles.
    task automatic run_instr(input bit drop_run, output int f, output int d, output int w, output int r);
        bit seen = 0;
        bit done = 0;
        f = int'(mif.imem_req);
        d = 0;
        w = 0;
        r = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (drop_run && state == S_MEM) run = 1'b0;
            f += int'(mif.imem_req);
            d += int'(mif.dmem_req);
            w += int'(mif.dmem_req && mif.dmem_we);
            r += int'(rf_we);
            if (state == S_DECODE) seen = 1;
            else if (seen && (state == S_FETCH || state == S_PAUSE || state == S_HALT)) done = 1;
        end
        check("instr_completes", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        run        = 1'b0;
        rand_run   = 0;
        resetl     = 1'b0;
        imem_block = 0;
        dmem_block = 0;
        repeat (2) @(negedge CLK);
        resetl = 1'b1;
    endtask

    initial begin
        int f, d, w, r, cnt;
        bit got;
        run = 1'b0; startpc = '0; resetl = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_state", 64'(state), 64'(S_IDLE));
        check("reset_pc", pc, 64'd0);
        check("reset_instr", 64'(instr), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        check("reset_strobes", {58'd0, mif.imem_req, mif.dmem_req, mif.dmem_we, rf_we, halted, timeout_err}, 64'd0);
        resetl = 1'b1;
        @(negedge CLK);
        check("idle_hold", 64'(state), 64'(S_IDLE));

        istream.push_back(mk(OP_ALU, 0, 0));
        istream.push_back(mk(OP_NOP, 1, 5));
        istream.push_back(mk(OP_CBZ, 1, -2));
        istream.push_back(mk(OP_NOP, 0, 0));
        istream.push_back(mk(OP_NOP, 0, 0));
        istream.push_back(mk(OP_CBZ, 0, -2));
        istream.push_back(mk(OP_LD, 0, 0));
        istream.push_back(mk(OP_ST, 0, 0));
        istream.push_back(HALT_I);
        imem_wait = 0;
        startpc = 64'h100;
        run = 1'b1;

        // ADD, zero-wait
        @(negedge CLK);
        check("t1_fetch", {61'd0, state}, 64'(S_FETCH));
        check("t1_addr", mif.imem_addr, 64'h100);
        @(negedge CLK);
        check("t1_decode", 64'(state), 64'(S_DECODE));
        @(negedge CLK);
        check("t1_exec", 64'(state), 64'(S_EXEC));
        @(negedge CLK);
        check("t1_wb", {state, rf_we}, {3'(S_WB), 1'b1});
        @(negedge CLK);
        check("t1_next", {state, rf_we}, {3'(S_FETCH), 1'b0});
        check("t1_pc", pc, 64'h104);
        check("t1_retired", 64'(retired), 64'd1);

        run_instr(0, f, d, w, r);
        check("nop_pc", pc, 64'h108);
        check("nop_no_rfwe", 64'(r), 64'd0);
        run_instr(0, f, d, w, r);
        check("cbz_taken_pc", pc, 64'h100);
        check("cbz_taken_ret", 64'(retired), 64'd3);
        run_instr(0, f, d, w, r);
        run_instr(0, f, d, w, r);
        run_instr(0, f, d, w, r);
        check("cbz_not_taken_pc", pc, 64'h10C);

        dmem_wait = 3;
        run_instr(0, f, d, w, r);
        check("ld_req_cycles", 64'(d), 64'd4);
        check("ld_we", 64'(w), 64'd0);
        check("ld_rfwe", 64'(r), 64'd1);
        check("ld_pc", pc, 64'h110);
        check("ld_retired", 64'(retired), 64'd7);

        dmem_wait = 2;
        run_instr(1, f, d, w, r);
        check("st_pause_state", 64'(state), 64'(S_PAUSE));
        check("st_we_cycles", {32'(d), 32'(w)}, {32'd3, 32'd3});
        check("st_rfwe", 64'(r), 64'd0);
        check("st_pc", pc, 64'h114);
        check("st_retired", 64'(retired), 64'd8);
        repeat (3) @(negedge CLK);
        check("pause_hold", {60'd0, state, mif.imem_req}, {60'd0, 3'(S_PAUSE), 1'b0});
        run = 1'b1;
        @(negedge CLK);
        check("resume_fetch", {61'd0, state}, 64'(S_FETCH));
        check("resume_addr", mif.imem_addr, 64'h114);

        run_instr(0, f, d, w, r);
        check("halt_state", {60'd0, state, halted}, {60'd0, 3'(S_HALT), 1'b1});
        check("halt_retired", 64'(retired), 64'd8);
        check("halt_pc", pc, 64'h114);
        repeat (3) @(negedge CLK);
        check("halt_sticky", {60'd0, state, mif.imem_req}, {60'd0, 3'(S_HALT), 1'b0});

        // asynchronous reset mid-FETCH
        do_reset();
        imem_block = 1;
        startpc = 64'h200;
        run = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_pre_req", 64'(mif.imem_req), 64'd1);
        #2 resetl = 1'b0;
        #1;
        check("rst_async_req", 64'(mif.imem_req), 64'd0);
        check("rst_async_state", {state, pc}, {3'(S_IDLE), 64'd0});
        run = 1'b0;
        @(negedge CLK);
        resetl = 1'b1;

        // fetch watchdog
        run = 1'b1;
        cnt = 0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge CLK);
            cnt += int'(mif.imem_req);
            if (state == S_HALT) got = 1;
        end
        check("to_halt", 64'(got), 64'd1);
        check("to_req_cycles", 64'(cnt), 64'(MAX_WAIT));
        check("to_flags", {61'd0, timeout_err, halted, mif.imem_req}, 64'b110);

        // data watchdog on a load
        do_reset();
        istream.delete();
        istream.push_back(mk(OP_LD, 0, 0));
        dmem_block = 1;
        run = 1'b1;
        cnt = 0; r = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge CLK);
            cnt += int'(mif.dmem_req);
            r += int'(rf_we);
            if (state == S_HALT) got = 1;
        end
        check("dto_halt", 64'(got), 64'd1);
        check("dto_req_cycles", 64'(cnt), 64'(MAX_WAIT));
        check("dto_flags", {60'd0, timeout_err, mif.dmem_req, 1'b0, 1'(r != 0)}, {60'd0, 4'b1000});
        check("dto_retired", 64'(retired), 64'd0);

        // randomized programs through the scoreboard
        for (int round = 0; round < 3; round++) begin
            do_reset();
            istream.delete();
            exp_q.delete();
            startpc = {$urandom, $urandom} & ~64'h3;
            model_program(startpc, 40);
            imem_wait = -1;
            dmem_wait = -1;
            spurious = 1;
            mon_en = 1;
            run = 1'b1;
            rand_run = 1;
            got = 0;
            for (int i = 0; i < 4000 && !got; i++) begin
                @(negedge CLK);
                if (halted) got = 1;
            end
            check("rand_halt_reached", 64'(got), 64'd1);
            rand_run = 0;
            run = 1'b1;
            repeat (2) @(negedge CLK);
            mon_en = 0;
            spurious = 0;
            check("rand_sb_drained", 64'(exp_q.size()), 64'd0);
            check("rand_pc", pc, model_pc);
            check("rand_retired", 64'(retired), 64'(model_ret));
            check("rand_no_timeout", 64'(timeout_err), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
